// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Front-end driver for an external alu32. It accepts one RV32I ALU (OP or
//   OP-IMM) or branch instruction together with its rs1/rs2 values, decodes it
//   into alu32's f/b/shamt encoding, and holds the ALU inputs for one EXEC
//   cycle. It then captures alu_y/alu_zero and returns the result and branch
//   decision over a valid/ready response port. One operation is in flight at
//   a time, so the peak rate is one operation every three cycles.
//
//   Optional feature macro: ALU_EXT_EN
//     defined   : OP with funct7=0100000 is also legal for funct3 001
//                 (f=1001, arithmetic left shift) and 110 (f=1110, NOR).
//     undefined : those encodings decode as illegal.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_instr/req_rs1/req_rs2  instruction word and operand values
//   alu_a/alu_b/alu_shamt/alu_f  registered alu32 inputs, f = {switch, op}
//   alu_y/alu_zero             alu32 result and zero flag
//   rsp_valid/rsp_ready        response handshake
//   rsp_result/rsp_taken/rsp_illegal  captured result, branch decision, flag
//   ops_done                   completed responses, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int          CNT_W          = 16,
  parameter logic [31:0] ILLEGAL_RESULT = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_instr,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_f,
  input  logic [31:0]      alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_taken,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [1:0] state;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  logic        dec_illegal_p0;
  logic        dec_branch_p0;
  logic        dec_use_zero_p0;
  logic        dec_invert_p0;
  logic [31:0] dec_b_p0;
  logic [4:0]  dec_shamt_p0;
  logic [3:0]  dec_f_p0;

  logic illegal_p1;
  logic branch_p1;
  logic use_zero_p1;
  logic invert_p1;

  // Register/rd fields are not needed by the ALU path.
  logic unused_instr_bits;
  assign unused_instr_bits = ^req_instr[19:7];

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    logic signed [11:0] s;
    s = imm;
    return 32'(s);
  endfunction

  // funct3 values that may carry the alternate funct7 (0100000) in OP.
  function automatic logic op_alt_ok(input logic [2:0] f3);
`ifdef ALU_EXT_EN
    return (f3 == 3'b000) || (f3 == 3'b101) || (f3 == 3'b001) || (f3 == 3'b110);
`else
    return (f3 == 3'b000) || (f3 == 3'b101);
`endif
  endfunction

  assign opcode = req_instr[6:0];
  assign funct3 = req_instr[14:12];
  assign funct7 = req_instr[31:25];

  // ---- stage p0: combinational decode of the presented request ----
  always_comb begin
    dec_illegal_p0  = 1'b0;
    dec_branch_p0   = 1'b0;
    dec_use_zero_p0 = 1'b0;
    dec_invert_p0   = 1'b0;
    dec_b_p0        = req_rs2;
    dec_shamt_p0    = req_rs2[4:0];
    dec_f_p0        = {1'b0, funct3};
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE || (funct7 == F7_ALT && op_alt_ok(funct3)))
          dec_f_p0 = {req_instr[30], funct3};
        else
          dec_illegal_p0 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_b_p0     = sext12(req_instr[31:20]);
        dec_shamt_p0 = req_instr[24:20];
        if (funct3 == 3'b001) begin
          if (funct7 != F7_BASE) dec_illegal_p0 = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE || funct7 == F7_ALT)
            dec_f_p0 = {req_instr[30], funct3};
          else
            dec_illegal_p0 = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec_branch_p0 = 1'b1;
        case (funct3)
          3'b000: begin dec_f_p0 = 4'b1000; dec_use_zero_p0 = 1'b1; end
          3'b001: begin dec_f_p0 = 4'b1000; dec_use_zero_p0 = 1'b1; dec_invert_p0 = 1'b1; end
          3'b100: dec_f_p0 = 4'b0010;
          3'b101: begin dec_f_p0 = 4'b0010; dec_invert_p0 = 1'b1; end
          3'b110: dec_f_p0 = 4'b0011;
          3'b111: begin dec_f_p0 = 4'b0011; dec_invert_p0 = 1'b1; end
          default: dec_illegal_p0 = 1'b1;
        endcase
      end
      default: dec_illegal_p0 = 1'b1;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_shamt   <= '0;
      alu_f       <= '0;
      illegal_p1  <= 1'b0;
      branch_p1   <= 1'b0;
      use_zero_p1 <= 1'b0;
      invert_p1   <= 1'b0;
      rsp_result  <= '0;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
      ops_done    <= '0;
    end else begin
      case (state)
        // ---- stage p0 -> p1: latch decode onto the ALU inputs ----
        IDLE: begin
          if (req_valid) begin
            alu_a       <= req_rs1;
            alu_b       <= dec_b_p0;
            alu_shamt   <= dec_shamt_p0;
            alu_f       <= dec_f_p0;
            illegal_p1  <= dec_illegal_p0;
            branch_p1   <= dec_branch_p0;
            use_zero_p1 <= dec_use_zero_p0;
            invert_p1   <= dec_invert_p0;
            state       <= EXEC;
          end
        end
        // ---- stage p1 -> p2: capture alu32 outputs into the response ----
        EXEC: begin
          rsp_illegal <= illegal_p1;
          rsp_result  <= illegal_p1 ? ILLEGAL_RESULT : alu_y;
          // BEQ/BNE look at zero from a subtract; the others at slt/sltu bit 0.
          rsp_taken   <= !illegal_p1 && branch_p1 &&
                         ((use_zero_p1 ? alu_zero : alu_y[0]) ^ invert_p1);
          state       <= RESP;
        end
        // ---- stage p2: hold the response until the consumer takes it ----
        RESP: begin
          if (rsp_ready) begin
            ops_done <= ops_done + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
